// File: rtl/sim_mon_pkg.sv
// Shared types and default constants for the simulation exit monitor.
package sim_mon_pkg;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } sim_status_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } mon_state_e;

  localparam logic [63:0] DEF_PASS_CODE  = 64'h0000000444333222;
  localparam logic [63:0] DEF_FAIL_CODE  = 64'h0000002382348720;
  localparam logic [39:0] DEF_PRINT_ADDR = 40'h0090000000;

endpackage

// File: rtl/sim_mon_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO with full/empty flags.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module sim_mon_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sim_exit_monitor.sv
// Simulation-control monitor: magic-code detection, no-retire watchdog,
// console character extraction from AXI writes, and final status reporting.
module sim_exit_monitor
  import sim_mon_pkg::*;
#(
  parameter int unsigned       NUM_HARTS   = 2,
  parameter int unsigned       WB_PORTS    = 2,
  parameter int unsigned       ADDR_W      = 40,
  parameter int unsigned       DATA_W      = 128,
  parameter logic [ADDR_W-1:0] PRINT_ADDR  = ADDR_W'(DEF_PRINT_ADDR),
  parameter logic [63:0]       PASS_CODE   = DEF_PASS_CODE,
  parameter logic [63:0]       FAIL_CODE   = DEF_FAIL_CODE,
  parameter int unsigned       WDOG_CYCLES = 100000000,
  parameter int unsigned       CHAR_DEPTH  = 16,
  parameter int unsigned       OST_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_HARTS-1:0]    retire,
  input  logic [WB_PORTS-1:0]     wb_vld,
  input  logic [WB_PORTS*64-1:0]  wb_data,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [ADDR_W-1:0]       awaddr,
  input  logic [7:0]              awlen,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic                    wlast,
  input  logic [DATA_W/8-1:0]     wstrb,
  input  logic [DATA_W-1:0]       wdata,
  output logic [7:0]              char_data,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    sim_done,
  output logic [1:0]              sim_status,
  output logic [31:0]             cycle_cnt,
  output logic [NUM_HARTS*32-1:0] retire_cnt,
  output logic [15:0]             drop_cnt
);

  mon_state_e  state;
  sim_status_e status_q;
  logic        hit_pass, hit_fail, hit_pass_q, hit_fail_q;
  logic [31:0] idle_cnt;
  logic        any_retire, timeout;

  logic        aw_hs, aw_match, w_end;
  logic        ost_push, ost_pop, ost_dout, ost_full, ost_empty, ost_drop;
  logic        sel_bit;
  logic [7:0]  lane_byte;
  logic        lane_found;
  logic        char_push, char_full, char_empty, char_drop;
  logic [15:0] drop_inc;

  // Magic-code compare across all writeback ports.
  always_comb begin
    hit_pass = 1'b0;
    hit_fail = 1'b0;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (wb_vld[p] && (wb_data[64*p +: 64] == PASS_CODE)) hit_pass = 1'b1;
      if (wb_vld[p] && (wb_data[64*p +: 64] == FAIL_CODE)) hit_fail = 1'b1;
    end
  end

  assign any_retire = |retire;
  assign timeout    = (state == RUN) && !any_retire && (idle_cnt == 32'(WDOG_CYCLES - 1));

  assign aw_hs    = awvalid && awready;
  assign aw_match = (awaddr == PRINT_ADDR) && (awlen == 8'd0);
  assign w_end    = wvalid && wready && wlast;

  // When the decision FIFO is empty, a W-last beat takes the decision of an
  // AW accepted in the same cycle directly, and that AW is not queued.
  assign ost_pop  = w_end && !ost_empty;
  assign ost_push = aw_hs && !(w_end && ost_empty);
  assign ost_drop = ost_push && ost_full && !ost_pop;
  assign sel_bit  = ost_empty ? (aw_hs && aw_match) : ost_dout;

  // Pick the byte at the lowest enabled strobe lane.
  always_comb begin
    lane_byte  = '0;
    lane_found = 1'b0;
    for (int unsigned k = 0; k < DATA_W/8; k++) begin
      if (wstrb[k] && !lane_found) begin
        lane_byte  = wdata[8*k +: 8];
        lane_found = 1'b1;
      end
    end
  end

  assign char_push  = w_end && sel_bit && lane_found && (state == RUN);
  assign char_drop  = char_push && char_full && !char_ready;
  assign drop_inc   = 16'(ost_drop) + 16'(char_drop);
  assign char_valid = !char_empty;
  assign sim_done   = (state == DONE);
  assign sim_status = status_q;

  sim_mon_sync_fifo #(.WIDTH(1), .DEPTH(OST_DEPTH)) u_ost_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ost_push),
    .din   (aw_match),
    .pop   (ost_pop),
    .dout  (ost_dout),
    .full  (ost_full),
    .empty (ost_empty)
  );

  sim_mon_sync_fifo #(.WIDTH(8), .DEPTH(CHAR_DEPTH)) u_char_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_push),
    .din   (lane_byte),
    .pop   (char_ready),
    .dout  (char_data),
    .full  (char_full),
    .empty (char_empty)
  );

  // Hit registration, watchdog and RUN/DRAIN/DONE sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      status_q   <= ST_NONE;
      hit_pass_q <= 1'b0;
      hit_fail_q <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      hit_pass_q <= hit_pass;
      hit_fail_q <= hit_fail;
      if (any_retire)        idle_cnt <= '0;
      else if (state == RUN) idle_cnt <= idle_cnt + 32'd1;
      case (state)
        RUN: begin
          if (hit_fail_q) begin
            state    <= DRAIN;
            status_q <= ST_FAIL;
          end else if (hit_pass_q) begin
            state    <= DRAIN;
            status_q <= ST_PASS;
          end else if (timeout) begin
            state    <= DRAIN;
            status_q <= ST_TIMEOUT;
          end
        end
        DRAIN:   if (char_empty) state <= DONE;
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  // Free-running cycle, per-hart retire and saturating drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (retire[h]) retire_cnt[32*h +: 32] <= retire_cnt[32*h +: 32] + 32'd1;
      end
      if (drop_cnt > (16'hFFFF - drop_inc)) drop_cnt <= '1;
      else                                  drop_cnt <= drop_cnt + drop_inc;
    end
  end

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Self-checking bench for sim_exit_monitor against a queue-based reference model.
module tb_sim_exit_monitor;

  localparam logic [39:0] PA    = 40'h0090000000;
  localparam logic [63:0] PASSC = 64'h0000000444333222;
  localparam logic [63:0] FAILC = 64'h0000002382348720;
  localparam int          WD    = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   retire;
  logic [1:0]   wb_vld;
  logic [127:0] wb_data;
  logic         awvalid, awready;
  logic [39:0]  awaddr;
  logic [7:0]   awlen;
  logic         wvalid, wready, wlast;
  logic [15:0]  wstrb;
  logic [127:0] wdata;
  logic [7:0]   char_data;
  logic         char_valid, char_ready;
  logic         sim_done;
  logic [1:0]   sim_status;
  logic [31:0]  cycle_cnt;
  logic [63:0]  retire_cnt;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  sim_exit_monitor #(.WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .retire(retire), .wb_vld(wb_vld), .wb_data(wb_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wstrb(wstrb), .wdata(wdata),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .sim_done(sim_done), .sim_status(sim_status), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mstate 0=running, 1=draining, 2=finished.
  logic [7:0]  cq[$];
  bit          oq[$];
  int          mstate, mstatus, idle;
  bit          hd_pass, hd_fail;
  int unsigned mcyc, mret0, mret1, mdrop;
  int          dut_rx;
  logic [7:0]  last_ch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    retire  = {1'($urandom_range(0, 1)), 1'b1};
    wb_vld  = '0;
    wb_data = '0;
    awvalid = 1'b0; awready = 1'b0; awaddr = '0; awlen = '0;
    wvalid  = 1'b0; wready  = 1'b0; wlast  = 1'b0; wstrb = '0; wdata = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: advance the model from the pre-edge inputs, then compare.
  task automatic step();
    bit         aw_hs, w_end, used, bitv, p_hit, f_hit, to, anyr, done_ok;
    int         pre_sz;
    logic [7:0] ch;
    check("char_valid", char_valid, cq.size() != 0);
    if (char_ready && cq.size() != 0) check("char_data", char_data, cq[0]);
    if (char_ready && char_valid) begin
      dut_rx++;
      last_ch = char_data;
    end
    pre_sz = cq.size();
    anyr   = retire != 0;
    p_hit  = (wb_vld[0] && wb_data[63:0] == PASSC) || (wb_vld[1] && wb_data[127:64] == PASSC);
    f_hit  = (wb_vld[0] && wb_data[63:0] == FAILC) || (wb_vld[1] && wb_data[127:64] == FAILC);
    to     = (mstate == 0) && !anyr && (idle == WD - 1);
    aw_hs  = awvalid && awready;
    w_end  = wvalid && wready && wlast;
    used   = 1'b0;
    bitv   = 1'b0;
    if (w_end) begin
      if (oq.size() != 0) bitv = oq.pop_front();
      else begin
        bitv = aw_hs && awaddr == PA && awlen == 0;
        used = aw_hs;
      end
    end
    if (aw_hs && !used) begin
      if (oq.size() < 4) oq.push_back(awaddr == PA && awlen == 0);
      else if (mdrop < 65535) mdrop++;
    end
    if (char_ready && cq.size() != 0) void'(cq.pop_front());
    if (w_end && bitv && wstrb != 0 && mstate == 0) begin
      ch = 8'h00;
      for (int k = 15; k >= 0; k--) if (wstrb[k]) ch = wdata[8*k +: 8];
      if (cq.size() < 16) cq.push_back(ch);
      else if (mdrop < 65535) mdrop++;
    end
    done_ok = (mstate == 1) && (pre_sz == 0);
    if (mstate == 0) begin
      if (hd_fail)      begin mstate = 1; mstatus = 2; end
      else if (hd_pass) begin mstate = 1; mstatus = 1; end
      else if (to)      begin mstate = 1; mstatus = 3; end
      if (anyr) idle = 0; else idle++;
    end else begin
      if (done_ok) mstate = 2;
      if (anyr) idle = 0;
    end
    hd_pass = p_hit;
    hd_fail = f_hit;
    mcyc++;
    if (retire[0]) mret0++;
    if (retire[1]) mret1++;
    @(posedge clk);
    #1;
    check("sim_done", sim_done, mstate == 2);
    check("sim_status", sim_status, mstatus);
    check("drop_cnt", drop_cnt, mdrop);
    check("cycle_cnt", cycle_cnt, mcyc);
    check("retire_cnt", retire_cnt, {mret1, mret0});
  endtask

  task automatic do_reset();
    idle_in();
    char_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cq.delete(); oq.delete();
    mstate = 0; mstatus = 0; idle = 0; hd_pass = 0; hd_fail = 0;
    mcyc = 0; mret0 = 0; mret1 = 0; mdrop = 0;
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_char_valid", char_valid, 0);
    check("rst_char_data", char_data, 0);
    check("rst_sim_done", sim_done, 0);
    check("rst_sim_status", sim_status, 0);
  endtask

  task automatic wr(input logic [39:0] a, input logic [7:0] len, input logic [15:0] s,
                    input logic [127:0] d);
    idle_in();
    awvalid = 1'b1; awready = 1'b1; awaddr = a; awlen = len;
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; wstrb = s; wdata = d;
    step();
    idle_in();
  endtask

  task automatic code(input logic [1:0] v, input logic [127:0] d);
    idle_in();
    wb_vld = v;
    wb_data = d;
    step();
    idle_in();
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && mstate != 2; i++) step();
    check("done_reached", sim_done, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rx0, hit_cyc;
    logic [127:0] d;
    dut_rx = 0;
    last_ch = '0;

    // Print then pass, characters held back until after the code hit.
    do_reset();
    wr(PA, 8'd0, 16'h000F, {rnd128() >> 8, 8'h4F} );
    wr(PA, 8'd0, 16'h000F, {rnd128() >> 8, 8'h4B});
    wr(PA, 8'd0, 16'h000F, {rnd128() >> 8, 8'h0A});
    code(2'b01, {64'h0, PASSC});
    repeat (5) step();
    check("drain_hold", sim_done, 0);
    rx0 = dut_rx;
    char_ready = 1'b1;
    wait_done(40);
    check("print_rx", dut_rx - rx0, 3);
    check("print_last", last_ch, 8'h0A);
    check("pass_status", sim_status, 1);

    // Lane select with an interleaved non-print AW.
    do_reset();
    char_ready = 1'b1;
    idle_in(); awvalid = 1; awready = 1; awaddr = 40'h0080000000; awlen = 0; step();
    idle_in(); awvalid = 1; awready = 1; awaddr = PA; awlen = 0; step();
    idle_in(); wvalid = 1; wready = 1; wlast = 1; wstrb = 16'h000F; wdata = rnd128(); step();
    d = rnd128();
    d[103:96] = 8'h41;
    idle_in(); wvalid = 1; wready = 1; wlast = 1; wstrb = 16'hF000; wdata = d; step();
    idle_in();
    rx0 = dut_rx;
    repeat (4) step();
    check("lane_cnt", dut_rx - rx0, 1);
    check("lane_char", last_ch, 8'h41);

    // Backpressure: 20 writes into a 16-deep buffer.
    do_reset();
    char_ready = 1'b0;
    for (int i = 0; i < 20; i++) wr(PA, 8'd0, 16'(($urandom | 1) << $urandom_range(0, 15)), rnd128());
    check("bp_drop", drop_cnt, 4);
    check("bp_valid", char_valid, 1);
    rx0 = dut_rx;
    char_ready = 1'b1;
    repeat (20) step();
    check("bp_rx", dut_rx - rx0, 16);

    // Same-cycle pass and fail codes.
    do_reset();
    char_ready = 1'b1;
    code(2'b11, {FAILC, PASSC});
    wait_done(10);
    check("fail_prio", sim_status, 2);

    // Watchdog: retire only during the first 10 cycles.
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin idle_in(); step(); end
    idle_in();
    retire = '0;
    hit_cyc = -1;
    for (int i = 0; i < 100 && hit_cyc < 0; i++) begin
      step();
      if (sim_done) hit_cyc = int'(cycle_cnt);
    end
    check("wdog_window", (hit_cyc >= 58 && hit_cyc <= 62), 1);
    check("wdog_status", sim_status, 3);

    // Randomized traffic, then pass.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle_in();
      char_ready = 1'($urandom_range(0, 1));
      awvalid = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      awaddr  = ($urandom_range(0, 3) == 0) ? 40'h0080000000 : PA;
      awlen   = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
      wvalid  = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      wlast   = $urandom_range(0, 3) != 0;
      wstrb   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      wdata   = rnd128();
      wb_vld  = 2'($urandom);
      wb_data = rnd128();
      step();
    end
    char_ready = 1'b1;
    code(2'b10, {PASSC, 64'h0});
    wait_done(40);
    check("rand_status", sim_status, 1);

    // Reset pulsed while draining.
    do_reset();
    char_ready = 1'b0;
    wr(PA, 8'd0, 16'h0001, rnd128());
    code(2'b01, {64'h0, PASSC});
    repeat (3) step();
    check("mid_drain_done", sim_done, 0);
    check("mid_drain_status", sim_status, 1);
    do_reset();
    idle_in();
    step();
    check("restart_cycle", cycle_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sim_exit_monitor.md
Name: sim_exit_monitor

Overview:
Synthesizable, parametrised simulation-control monitor that sits beside the CPU top in the SoC testbench.
- Snoops multiple hart retire strobes and multiple writeback data ports, and detects the pass/fail magic codes.
- Runs a no-retire watchdog.
- Extracts console characters from single-beat AXI writes to a print address into a buffered character stream.
- Produces a final sim status once the console has drained, so the bench ends on a clean status word.

Parameters:
NUM_HARTS, 2, number of retire strobes / per-hart retire counters
WB_PORTS, 2, number of 64-bit writeback ports compared against the magic codes
ADDR_W, 40, AXI address width
DATA_W, 128, AXI write data width (multiple of 32)
PRINT_ADDR, 40'h0090000000, console print address
PASS_CODE, 64'h0000000444333222, pass magic value
FAIL_CODE, 64'h0000002382348720, fail magic value
WDOG_CYCLES, 100000000, consecutive no-retire cycles that trigger a timeout
CHAR_DEPTH, 16, character FIFO depth (power of 2)
OST_DEPTH, 4, outstanding-AW decision FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
retire  in  NUM_HARTS  per-hart retire strobe
wb_vld  in  WB_PORTS  writeback valid per port
wb_data  in  WB_PORTS*64  writeback data, port p at [64p+:64]
awvalid  in  1  snooped AW valid
awready  in  1  snooped AW ready
awaddr  in  ADDR_W  snooped AW address
awlen  in  8  snooped AW burst length
wvalid  in  1  snooped W valid
wready  in  1  snooped W ready
wlast  in  1  snooped W last
wstrb  in  DATA_W/8  snooped W strobes
wdata  in  DATA_W  snooped W data
char_data  out  8  console character
char_valid  out  1  character available
char_ready  in  1  consumer accepts character
sim_done  out  1  simulation finished, status final
sim_status  out  2  0 none, 1 pass, 2 fail, 3 timeout
cycle_cnt  out  32  cycles since reset, wraps
retire_cnt  out  NUM_HARTS*32  per-hart retired count, wraps
drop_cnt  out  16  characters dropped because the FIFO was full, saturating

Behaviour:
- Reset: all counters are 0; state is RUN; both FIFOs are empty; sim_done=0; sim_status=0; char_valid=0; char_data=0.
- Clock and reset: one clock, clk. rst is synchronous and active-high. rst asserted mid-operation (any state) returns everything to the reset values at the next edge.
- Stage 1 register: each cycle it captures code_hit_pass and code_hit_fail. A port hits when wb_vld[p] is set and wb_data[p] equals the code, OR-ed across ports.
- Stage 1 action: a hit in RUN moves the state to DRAIN at the next edge. Total latency from the wb input to the DRAIN state is 2 edges.
- Priority: when hits arrive in the same cycle, fail takes precedence over pass, and pass over timeout.
- sim_status latches when RUN is left and holds until reset.
- Watchdog: idle_cnt resets to 0 on any retire bit; otherwise it increments. When idle_cnt reaches WDOG_CYCLES-1 with no retire in RUN, the state goes to DRAIN with status timeout. The watchdog is frozen outside RUN.
- retire_cnt[h] increments on retire[h] in every state.
- AW snoop: on an AW handshake, push the bit match = (awaddr==PRINT_ADDR && awlen==0) into the OST FIFO.
- W snoop: on a W handshake with wlast, pop the OST FIFO. If the OST FIFO is empty in that cycle, the bit from an AW handshake in the same cycle is used (bypass).
- Character extraction: if the popped bit is 1 and any wstrb bit is set, the character is the byte at the lowest set strobe lane k, i.e. wdata[8k+:8]. wstrb==0 produces no character.
- OST overflow: an AW handshake while the OST FIFO is full (and no pop) is dropped and counted in drop_cnt.
- Character push: allowed only in RUN, including the cycle a code hit is being registered. If the char FIFO is full, the character is dropped and drop_cnt increments, saturating at 16'hFFFF.
- Simultaneous push and pop on a full char FIFO succeeds.
- char output: valid/ready handshake, first-word-fall-through. char_data is stable while char_valid && !char_ready.
- State machine:
  - RUN -> DRAIN on a code hit or timeout.
  - DRAIN -> DONE on the first edge where the char FIFO is empty.
  - DONE is terminal until reset; sim_done=1 in DONE.
- cycle_cnt increments every cycle after reset, wrapping at 2^32.

Decomposition:
- sim_mon_pkg holds:
  - status enum (ST_NONE, ST_PASS, ST_FAIL, ST_TIMEOUT);
  - state enum (RUN, DRAIN, DONE);
  - the default magic-code constants.
- One sub-module, sim_mon_sync_fifo: parametrised width and depth, FWFT, with full and empty flags. It is instantiated twice: the char FIFO (width 8) and the OST FIFO (width 1).

Test Plan:
- Print then pass: three single-beat writes to 0x90000000 with wstrb=16'h000F and bytes 'O','K','\n', then wb_data[0]=0x444333222. Required: chars 'O','K','\n' in order, sim_status=1, sim_done asserts only after the last char is accepted.
- Lane select and interleave: AW to 0x80000000, then AW to PRINT_ADDR, then two W beats; the second W has wstrb=16'hF000 and wdata[103:96]=0x41. Required: exactly one char 0x41.
- Backpressure: char_ready=0 while 20 chars are written. Required: 16 chars buffered, drop_cnt=4; releasing ready yields the first 16 chars in order.
- Watchdog: WDOG_CYCLES=50, no retire after cycle 10. Required: sim_status=3, with sim_done at cycle 60 ±2.
- Same-cycle codes: PASS_CODE on port 0 and FAIL_CODE on port 1 in the same cycle. Required: sim_status=2.
- Mid-drain reset: rst pulsed during DRAIN. Required: all outputs return to their reset values and cycle_cnt restarts from 0.
